// File: rtl/pipe_regs.sv
// Y86-64 pipeline register bank: F/D/E/M/W stage registers, condition codes,
// control-conflict flag and cycle/bubble event counters.

package pipe_regs_pkg;

    localparam int unsigned PC_W = 64;
    localparam int unsigned D_W  = 147;
    localparam int unsigned E_W  = 223;
    localparam int unsigned M_W  = 144;
    localparam int unsigned W_W  = 143;
    localparam int unsigned CC_W = 3;

    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [3:0] INOP  = 4'd1;
    localparam logic [3:0] RNONE = 4'd15;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    // The listed E fields total 219 bits; the low 4 bits of the 223-bit bus are reserved.
    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic [3:0]  rsvd;
    } e_reg_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } m_reg_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } w_reg_t;

    // NOP (bubble) patterns for each stage
    function automatic d_reg_t d_nop();
        d_reg_t r;
        r       = '0;
        r.stat  = SAOK;
        r.icode = INOP;
        r.ra    = RNONE;
        r.rb    = RNONE;
        return r;
    endfunction

    function automatic e_reg_t e_nop();
        e_reg_t r;
        r       = '0;
        r.stat  = SAOK;
        r.icode = INOP;
        r.dste  = RNONE;
        r.dstm  = RNONE;
        r.srca  = RNONE;
        r.srcb  = RNONE;
        return r;
    endfunction

    function automatic m_reg_t m_nop();
        m_reg_t r;
        r       = '0;
        r.stat  = SAOK;
        r.icode = INOP;
        r.dste  = RNONE;
        r.dstm  = RNONE;
        return r;
    endfunction

    function automatic w_reg_t w_nop();
        w_reg_t r;
        r       = '0;
        r.stat  = SAOK;
        r.icode = INOP;
        r.dste  = RNONE;
        r.dstm  = RNONE;
        return r;
    endfunction

endpackage

module pipe_regs
    import pipe_regs_pkg::*;
#(
    parameter int unsigned W_CNT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic              E_bubble,
    input  logic              M_bubble,
    input  logic              W_stall,
    input  logic              set_CC,
    input  logic [PC_W-1:0]   f_predPC,
    output logic [PC_W-1:0]   F_predPC,
    input  logic [D_W-1:0]    D_in,
    output logic [D_W-1:0]    D_out,
    input  logic [E_W-1:0]    E_in,
    output logic [E_W-1:0]    E_out,
    input  logic [M_W-1:0]    M_in,
    output logic [M_W-1:0]    M_out,
    input  logic [W_W-1:0]    W_in,
    output logic [W_W-1:0]    W_out,
    input  logic [CC_W-1:0]   cc_in,
    output logic [CC_W-1:0]   CC,
    output logic              halted,
    output logic              ctl_err,
    output logic [W_CNT-1:0]  cycle_cnt,
    output logic [W_CNT-1:0]  bubble_cnt
);

    localparam int unsigned CNT_EXT_W = W_CNT + 1;

    logic [PC_W-1:0]  f_pc_q,    f_pc_d;
    d_reg_t           d_q,       d_d;
    e_reg_t           e_q,       e_d;
    m_reg_t           m_q,       m_d;
    w_reg_t           w_q,       w_d;
    logic [CC_W-1:0]  cc_q,      cc_d;
    logic             halted_q,  halted_d;
    logic             ctl_err_q, ctl_err_d;
    logic [W_CNT-1:0] cyc_q,     cyc_d;
    logic [W_CNT-1:0] bub_q,     bub_d;

    logic [1:0]         bub_inc;
    logic [W_CNT:0]     bub_sum;

    // Next-state: stall holds, bubble inserts NOP, otherwise load; counters saturate
    always_comb begin
        f_pc_d    = f_pc_q;
        d_d       = d_q;
        e_d       = e_q;
        m_d       = m_q;
        w_d       = w_q;
        cc_d      = cc_q;
        cyc_d     = cyc_q;
        bub_d     = bub_q;
        bub_inc   = 2'd0;
        bub_sum   = '0;

        if (!F_stall) begin
            f_pc_d = f_predPC;
        end

        if (D_stall) begin
            d_d = d_q;
        end else if (D_bubble) begin
            d_d = d_nop();
        end else begin
            d_d = d_reg_t'(D_in);
        end

        e_d = E_bubble ? e_nop() : e_reg_t'(E_in);
        m_d = M_bubble ? m_nop() : m_reg_t'(M_in);
        w_d = W_stall  ? w_q     : w_reg_t'(W_in);

        if (set_CC) begin
            cc_d = cc_in;
        end

        halted_d  = (w_d.stat != SAOK);
        ctl_err_d = ctl_err_q | (D_stall & D_bubble);

        if (!W_stall && (cyc_q != {W_CNT{1'b1}})) begin
            cyc_d = cyc_q + W_CNT'(1);
        end

        // A D bubble suppressed by D_stall does not count
        bub_inc = {1'b0, D_bubble & ~D_stall} + {1'b0, E_bubble};
        bub_sum = {1'b0, bub_q} + CNT_EXT_W'(bub_inc);
        bub_d   = bub_sum[W_CNT] ? {W_CNT{1'b1}} : bub_sum[W_CNT-1:0];
    end

    // State registers with asynchronous reset to NOP / initial values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc_q    <= '0;
            d_q       <= d_nop();
            e_q       <= e_nop();
            m_q       <= m_nop();
            w_q       <= w_nop();
            cc_q      <= 3'b100;
            halted_q  <= 1'b0;
            ctl_err_q <= 1'b0;
            cyc_q     <= '0;
            bub_q     <= '0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_q       <= d_d;
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            cc_q      <= cc_d;
            halted_q  <= halted_d;
            ctl_err_q <= ctl_err_d;
            cyc_q     <= cyc_d;
            bub_q     <= bub_d;
        end
    end

    assign F_predPC   = f_pc_q;
    assign D_out      = D_W'(d_q);
    assign E_out      = E_W'(e_q);
    assign M_out      = M_W'(m_q);
    assign W_out      = W_W'(w_q);
    assign CC         = cc_q;
    assign halted     = halted_q;
    assign ctl_err    = ctl_err_q;
    assign cycle_cnt  = cyc_q;
    assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Directed bench for pipe_regs: reset, load-use stall, mispredict, conflict,
// halt freeze, asynchronous mid-run reset and counter saturation.

module tb_pipe_regs;

    logic clk;
    logic rst_n;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_CC;
    logic [63:0]  f_predPC;
    logic [146:0] D_in;
    logic [222:0] E_in;
    logic [143:0] M_in;
    logic [142:0] W_in;
    logic [2:0]   cc_in;

    logic [63:0]  F_predPC;
    logic [146:0] D_out;
    logic [222:0] E_out;
    logic [143:0] M_out;
    logic [142:0] W_out;
    logic [2:0]   CC;
    logic         halted, ctl_err;
    logic [31:0]  cycle_cnt, bubble_cnt;

    logic [63:0]  s_F;
    logic [146:0] s_D;
    logic [222:0] s_E;
    logic [143:0] s_M;
    logic [142:0] s_W;
    logic [2:0]   s_CC;
    logic         s_halted, s_ctl_err;
    logic [3:0]   s_cycle, s_bubble;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cyc = 0;

    localparam logic [146:0] D_NOP = {3'd1, 4'd1, 4'd0, 4'hf, 4'hf, 64'd0, 64'd0};
    localparam logic [222:0] E_NOP = {3'd1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0,
                                      4'hf, 4'hf, 4'hf, 4'hf, 4'h0};
    localparam logic [143:0] M_NOP = {3'd1, 4'd1, 1'b0, 64'd0, 64'd0, 4'hf, 4'hf};
    localparam logic [142:0] W_NOP = {3'd1, 4'd1, 64'd0, 64'd0, 4'hf, 4'hf};

    pipe_regs #(.W_CNT(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_CC(set_CC), .f_predPC(f_predPC), .F_predPC(F_predPC),
        .D_in(D_in), .D_out(D_out), .E_in(E_in), .E_out(E_out),
        .M_in(M_in), .M_out(M_out), .W_in(W_in), .W_out(W_out),
        .cc_in(cc_in), .CC(CC), .halted(halted), .ctl_err(ctl_err),
        .cycle_cnt(cycle_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_regs #(.W_CNT(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_CC(set_CC), .f_predPC(f_predPC), .F_predPC(s_F),
        .D_in(D_in), .D_out(s_D), .E_in(E_in), .E_out(s_E),
        .M_in(M_in), .M_out(s_M), .W_in(W_in), .W_out(s_W),
        .cc_in(cc_in), .CC(s_CC), .halted(s_halted), .ctl_err(s_ctl_err),
        .cycle_cnt(s_cycle), .bubble_cnt(s_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [146:0] dv(input logic [3:0] icode, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [63:0] valc,
                                        input logic [63:0] valp);
        return {3'd1, icode, 4'd0, ra, rb, valc, valp};
    endfunction

    function automatic logic [222:0] ev(input logic [3:0] icode, input logic [63:0] valc,
                                        input logic [63:0] vala, input logic [63:0] valb,
                                        input logic [3:0] dste, input logic [3:0] dstm);
        return {3'd1, icode, 4'd0, valc, vala, valb, dste, dstm, 4'h2, 4'h3, 4'h0};
    endfunction

    function automatic logic [143:0] mv(input logic [3:0] icode, input logic cnd,
                                        input logic [63:0] vale, input logic [3:0] dste);
        return {3'd1, icode, cnd, vale, 64'h55, dste, 4'hf};
    endfunction

    function automatic logic [142:0] wv(input logic [2:0] stat, input logic [3:0] icode,
                                        input logic [63:0] vale, input logic [63:0] valm);
        return {stat, icode, vale, valm, 4'h4, 4'hf};
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; the cycle-count model follows W_stall as sampled at that edge
    task automatic step();
        if (!W_stall) exp_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0;
        M_bubble = 0; W_stall = 0; set_CC = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        clear_ctl();
        f_predPC = '0; D_in = '0; E_in = '0; M_in = '0; W_in = '0; cc_in = '0;
        #12;

        // Reset values
        check_eq("rst_D",   256'(D_out), 256'(D_NOP));
        check_eq("rst_E",   256'(E_out), 256'(E_NOP));
        check_eq("rst_M",   256'(M_out), 256'(M_NOP));
        check_eq("rst_W",   256'(W_out), 256'(W_NOP));
        check_eq("rst_F",   256'(F_predPC), 256'(0));
        check_eq("rst_CC",  256'(CC), 256'(3'b100));
        check_eq("rst_cnt", 256'({cycle_cnt, bubble_cnt, ctl_err, halted}), 256'(0));

        @(posedge clk);
        #1;
        rst_n = 1;
        exp_cyc = 0;

        // First load after release
        f_predPC = 64'h100;
        D_in = dv(4'd3, 4'hf, 4'd3, 64'h10, 64'h0a);
        E_in = ev(4'd6, 64'h0, 64'h7, 64'h9, 4'd3, 4'hf);
        M_in = mv(4'd6, 1'b1, 64'h10, 4'd3);
        W_in = wv(3'd1, 4'd6, 64'h20, 64'h0);
        set_CC = 1; cc_in = 3'b011;
        check_eq("pre_edge_D", 256'(D_out), 256'(D_NOP));
        step();
        check_eq("load_D",  256'(D_out), 256'(dv(4'd3, 4'hf, 4'd3, 64'h10, 64'h0a)));
        check_eq("load_E",  256'(E_out), 256'(ev(4'd6, 64'h0, 64'h7, 64'h9, 4'd3, 4'hf)));
        check_eq("load_M",  256'(M_out), 256'(mv(4'd6, 1'b1, 64'h10, 4'd3)));
        check_eq("load_W",  256'(W_out), 256'(wv(3'd1, 4'd6, 64'h20, 64'h0)));
        check_eq("load_F",  256'(F_predPC), 256'(64'h100));
        check_eq("load_CC", 256'(CC), 256'(3'b011));
        check_eq("load_cyc", 256'(cycle_cnt), 256'(1));
        check_eq("load_halted", 256'(halted), 256'(0));

        // Load-use stall: F/D hold, E bubbles
        F_stall = 1; D_stall = 1; E_bubble = 1; set_CC = 0; cc_in = 3'b111;
        f_predPC = 64'h200;
        D_in = dv(4'd5, 4'd1, 4'd2, 64'h8, 64'h14);
        E_in = ev(4'd5, 64'h8, 64'h1, 64'h2, 4'hf, 4'd1);
        M_in = mv(4'd3, 1'b0, 64'h30, 4'd2);
        step();
        check_eq("lu_F",   256'(F_predPC), 256'(64'h100));
        check_eq("lu_D",   256'(D_out), 256'(dv(4'd3, 4'hf, 4'd3, 64'h10, 64'h0a)));
        check_eq("lu_E",   256'(E_out), 256'(E_NOP));
        check_eq("lu_M",   256'(M_out), 256'(mv(4'd3, 1'b0, 64'h30, 4'd2)));
        check_eq("lu_CC",  256'(CC), 256'(3'b011));
        check_eq("lu_bub", 256'(bubble_cnt), 256'(1));
        check_eq("lu_err", 256'(ctl_err), 256'(0));

        // Release of the stall
        clear_ctl();
        step();
        check_eq("rel_F", 256'(F_predPC), 256'(64'h200));
        check_eq("rel_D", 256'(D_out), 256'(dv(4'd5, 4'd1, 4'd2, 64'h8, 64'h14)));
        check_eq("rel_E", 256'(E_out), 256'(ev(4'd5, 64'h8, 64'h1, 64'h2, 4'hf, 4'd1)));

        // Mispredict: D and E bubble together, M bubble as well
        D_bubble = 1; E_bubble = 1; M_bubble = 1;
        D_in = dv(4'd7, 4'hf, 4'hf, 64'h40, 64'h49);
        step();
        check_eq("mp_D",   256'(D_out), 256'(D_NOP));
        check_eq("mp_E",   256'(E_out), 256'(E_NOP));
        check_eq("mp_M",   256'(M_out), 256'(M_NOP));
        check_eq("mp_bub", 256'(bubble_cnt), 256'(3));
        clear_ctl();

        // Conflict: D_stall and D_bubble together
        D_in = dv(4'd2, 4'd4, 4'd5, 64'h0, 64'h60);
        step();
        check_eq("cf_pre_D", 256'(D_out), 256'(dv(4'd2, 4'd4, 4'd5, 64'h0, 64'h60)));
        D_stall = 1; D_bubble = 1;
        D_in = dv(4'd9, 4'hf, 4'hf, 64'h0, 64'h61);
        step();
        check_eq("cf_D",   256'(D_out), 256'(dv(4'd2, 4'd4, 4'd5, 64'h0, 64'h60)));
        check_eq("cf_err", 256'(ctl_err), 256'(1));
        check_eq("cf_bub", 256'(bubble_cnt), 256'(3));
        clear_ctl();
        step();
        check_eq("cf_rel_D",   256'(D_out), 256'(dv(4'd9, 4'hf, 4'hf, 64'h0, 64'h61)));
        check_eq("cf_err_sticky", 256'(ctl_err), 256'(1));

        // Halt: load SHLT into W, then stall W while W_in and cc_in change
        W_in = wv(3'd4, 4'd0, 64'h0, 64'h0);
        step();
        check_eq("halt_W",   256'(W_out), 256'(wv(3'd4, 4'd0, 64'h0, 64'h0)));
        check_eq("halt_flag", 256'(halted), 256'(1));
        W_stall = 1;
        for (int i = 0; i < 5; i++) begin
            W_in  = wv(3'd1, 4'd6, 64'(i + 1), 64'(i * 3));
            cc_in = 3'(i + 1);
            step();
            check_eq("halt_W_hold", 256'(W_out), 256'(wv(3'd4, 4'd0, 64'h0, 64'h0)));
            check_eq("halt_cyc",    256'(cycle_cnt), 256'(exp_cyc));
            check_eq("halt_CC",     256'(CC), 256'(3'b011));
            check_eq("halt_flag_hold", 256'(halted), 256'(1));
        end
        check_eq("halt_cyc_abs", 256'(cycle_cnt), 256'(8));

        // Asynchronous reset mid-cycle with W_stall still asserted
        #3;
        rst_n = 0;
        #1;
        check_eq("ar_W",      256'(W_out), 256'(W_NOP));
        check_eq("ar_D",      256'(D_out), 256'(D_NOP));
        check_eq("ar_F",      256'(F_predPC), 256'(0));
        check_eq("ar_CC",     256'(CC), 256'(3'b100));
        check_eq("ar_flags",  256'({ctl_err, halted}), 256'(0));
        check_eq("ar_cnt",    256'({cycle_cnt, bubble_cnt}), 256'(0));
        @(posedge clk);
        #1;
        clear_ctl();
        rst_n = 1;
        exp_cyc = 0;

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) step();
        check_eq("sat_cyc4",  256'(s_cycle), 256'(15));
        check_eq("sat_cyc32", 256'(cycle_cnt), 256'(exp_cyc));
        step();
        check_eq("sat_cyc4_hold", 256'(s_cycle), 256'(15));
        check_eq("sat_cyc32_abs", 256'(cycle_cnt), 256'(21));

        D_bubble = 1; E_bubble = 1;
        for (int i = 0; i < 8; i++) step();
        clear_ctl();
        check_eq("sat_bub4",  256'(s_bubble), 256'(15));
        check_eq("sat_bub32", 256'(bubble_cnt), 256'(16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_regs.md
# pipe_regs

Pipeline-register bank for the five-stage Y86-64 pipeline: holds the F (predicted PC), D, E, M and W stage registers and the condition-code register. It is the consumer of the stall, bubble and set_CC controls produced by pipeline control. On each clock edge it applies those controls as load, hold or NOP-insert, and it keeps two event counters for debug and performance. All outputs are registered; there is no combinational path from any `*_in` to any `*_out`.

## Interface
- `W_CNT`, 32: width of the cycle and bubble counters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall`  in  1 each  pipeline control.
- `set_CC`  in  1  condition-code load enable.
- `f_predPC`  in  64  next predicted PC.
- `F_predPC`  out  64  F register.
- `D_in` / `D_out`  in/out  147  {stat[2:0], icode[3:0], ifun[3:0], rA[3:0], rB[3:0], valC[63:0], valP[63:0]}.
- `E_in` / `E_out`  in/out  223  {stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB}.
- `M_in` / `M_out`  in/out  144  {stat, icode, Cnd[0], valE, valA, dstE, dstM}.
- `W_in` / `W_out`  in/out  143  {stat, icode, valE, valM, dstE, dstM}.
- `cc_in`  in  3  {ZF, SF, OF} from the ALU.
- `CC`  out  3  {ZF, SF, OF}.
- `halted`  out  1  high while W stat ≠ SAOK.
- `ctl_err`  out  1  sticky; set when a stall and a bubble are asserted together.
- `cycle_cnt`, `bubble_cnt`  out  `W_CNT`  event counters.

Field packing is MSB-first in the listed order. Encodings: SAOK=1, SADR=2, SINS=3, SHLT=4; INOP=1; RNONE=15.

## Operation
- **Per-register action at `posedge clk`, by priority:**
  1. stall → hold the current value.
  2. bubble → load the NOP pattern.
  3. otherwise → load `*_in`.
- **Control signals per register:**
  - F responds only to `F_stall`; it has no bubble.
  - D responds to `D_stall` and `D_bubble`.
  - E responds to `E_bubble` only.
  - M responds to `M_bubble` only.
  - W responds to `W_stall` only.
- **NOP pattern (all stages):**
  - stat = SAOK, icode = INOP, ifun = 0.
  - every register-ID field (rA, rB, srcA, srcB, dstE, dstM) = RNONE.
  - valC, valP, valA, valB, valE, valM = 0; Cnd = 0.
- **Stall and bubble together on D:** the stall wins (D holds) and `ctl_err` is set. `ctl_err` stays set until reset.
- **Condition codes:** CC loads `cc_in` only when `set_CC`=1; otherwise it holds.
- **`halted`:** equals (`W_out.stat` ≠ SAOK). It is decoded from the W register output only.
- **`cycle_cnt`:** +1 on every clock edge where `W_stall`=0. It saturates at all-ones and does not wrap.
- **`bubble_cnt`:** +1 on every edge where `D_bubble` or `E_bubble` takes effect. A D bubble suppressed by `D_stall` does not count. When both bubbles take effect in the same edge, the count is +2. It saturates at all-ones.
- **Values on reset (asynchronous, immediate):**
  - D, E, M, W = NOP pattern.
  - `F_predPC` = 0.
  - CC = {1, 0, 0}.
  - counters = 0, `ctl_err` = 0, `halted` = 0.

## Timing
- Every stage register has 1-cycle latency: `*_in` sampled at edge N appears on `*_out` after edge N.
- A stall asserted for k consecutive cycles holds the register for exactly k edges. Release takes effect at the first edge with the stall low.
- A bubble inserts exactly one NOP per asserting edge.
- Once W holds a non-SAOK stat and `W_stall` stays high, W and `cycle_cnt` freeze indefinitely. Other stages still follow their own controls.
- **Reset mid-operation:**
  - Asserting `rst_n` low clears all state asynchronously, within the same cycle, regardless of pending controls.
  - The first load after release happens at the first `posedge clk` with `rst_n`=1.
- All controls are sampled at the edge only; glitches between edges have no effect.

## Test plan
- **Reset.** Apply reset, then release, with all controls low. On the first edge drive `D_in` icode=3 (IIRMOVQ), valC=0x10. Required: before the edge `D_out` icode=1, rA=rB=15, CC=3'b100. After the edge `D_out` icode=3, valC=0x10.
- **Load-use stall.** Pulse `F_stall`=`D_stall`=`E_bubble`=1 for one edge. Required: `F_predPC` and `D_out` unchanged. `E_out` icode=1, dstE=dstM=15, stat=1. `bubble_cnt` +1. `ctl_err`=0.
- **Mispredict.** Assert `D_bubble`=`E_bubble`=1 for one edge. Required: `D_out` and `E_out` are both the NOP pattern; `bubble_cnt` +2.
- **Conflict.** Assert `D_stall`=`D_bubble`=1. Required: D holds its value, `ctl_err`=1, `bubble_cnt` unchanged. `ctl_err` stays 1 after the controls drop and clears only on reset.
- **Halt.** Load `W_in` stat=4 (SHLT), then assert `W_stall`=1 for 5 edges while changing `W_in`. Required: `halted`=1, `W_out` constant, `cycle_cnt` constant. Asserting `set_CC`=0 with a changing `cc_in` leaves CC unchanged.
- **Counter saturation.** With `W_CNT`=4, run 20 edges with all controls low. Required: `cycle_cnt`=15 and it stays 15.
